// File: rtl/ppg_infer_sched_if.sv
// ppg_infer_sched_if -- sample, network-control and result bundle for the inference sequencer. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

interface ppg_infer_sched_if #(
  parameter int WIN_LEN = 24,
  parameter int DW      = 16
);
  // Sample and result fields carry signed values; the sequencer never does arithmetic on them.
  logic                         s_valid;
  logic                         s_ready;
  logic [DW-1:0]                s_data;
  logic                         net_rst;
  logic                         net_start;
  logic [WIN_LEN-1:0][DW-1:0]   net_window;
  logic                         net_done;
  logic [DW-1:0]                net_result;
  logic                         m_valid;
  logic                         m_ready;
  logic [DW-1:0]                m_data;
  logic [15:0]                  m_index;
  logic                         err;

  modport master (
    input  s_valid, s_data, net_done, net_result, m_ready,
    output s_ready, net_rst, net_start, net_window, m_valid, m_data, m_index, err
  );

  modport slave (
    output s_valid, s_data, net_done, net_result, m_ready,
    input  s_ready, net_rst, net_start, net_window, m_valid, m_data, m_index, err
  );
endinterface

`default_nettype wire

// File: rtl/ppg_infer_sched.sv
// ppg_infer_sched -- slices PPG samples into overlapping windows and sequences one network inference per window. Rev 1.0
// Optional: define PPG_SCHED_TIMEOUT_EN to abandon a launch after TIMEOUT_CYC RUN cycles and raise sticky err.
`default_nettype none
`timescale 1ns/1ps

module ppg_infer_sched #(
  parameter int WIN_LEN     = 24,
  parameter int HOP         = 8,
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  ppg_infer_sched_if.master io_sched
);

  localparam int                  c_FILL_W   = $clog2(WIN_LEN + 1);
  localparam logic [c_FILL_W-1:0] c_WIN_CNT  = c_FILL_W'(WIN_LEN);
  localparam logic [c_FILL_W-1:0] c_HOP_CNT  = c_FILL_W'(HOP);
  localparam logic [c_FILL_W-1:0] c_FILL_ONE = c_FILL_W'(1);

  generate
    if ((HOP < 1) || (HOP > WIN_LEN) || (TIMEOUT_CYC < 1)) begin : g_bad_param
      $error("ppg_infer_sched: HOP or TIMEOUT_CYC out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [WIN_LEN-1:0][DW-1:0] r_window;
  logic [c_FILL_W-1:0]        r_fill_cnt;
  logic                       r_primed;
  logic [15:0]                r_win_idx;
  logic                       r_m_valid;
  logic [DW-1:0]              r_m_data;
  logic [15:0]                r_m_index;

  logic                       w_accept;
  logic [c_FILL_W-1:0]        w_fill_inc;
  logic [c_FILL_W-1:0]        w_need;
  logic                       w_fill_done;
  logic                       w_timeout;
  logic                       w_s_ready;
  logic                       w_net_rst;
  logic                       w_net_start;

  assign w_accept    = io_sched.s_valid && (r_state == S_FILL);
  assign w_fill_inc  = r_fill_cnt + c_FILL_ONE;
  assign w_need      = r_primed ? c_HOP_CNT : c_WIN_CNT;
  assign w_fill_done = w_accept && (w_fill_inc == w_need);

`ifdef PPG_SCHED_TIMEOUT_EN
  localparam int                 c_RUN_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(TIMEOUT_CYC - 1);
  localparam logic [c_RUN_W-1:0] c_RUN_ONE  = c_RUN_W'(1);

  logic [c_RUN_W-1:0] r_run_cnt;
  logic               r_err;

  // r_run_cnt equals the number of RUN cycles already spent, so the last allowed cycle is TIMEOUT_CYC-1.
  assign w_timeout = (r_state == S_RUN) && !io_sched.net_done && (r_run_cnt == c_RUN_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_RUN) r_run_cnt <= r_run_cnt + c_RUN_ONE;
      else                  r_run_cnt <= '0;
      if (w_timeout)        r_err     <= 1'b1;
    end
  end

  assign io_sched.err = r_err;
`else
  assign w_timeout    = 1'b0;
  assign io_sched.err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_net_rst   = 1'b0;
    w_net_start = 1'b0;
    unique case (r_state)
      S_FILL: begin
        w_s_ready = 1'b1;
        if (w_fill_done) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_net_rst   = 1'b1;
        w_state_nxt = S_START;
      end
      S_START: begin
        w_net_start = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (io_sched.net_done) w_state_nxt = S_OUT;
        else if (w_timeout)    w_state_nxt = S_FILL;
      end
      S_OUT: begin
        if (io_sched.m_ready) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FILL;
      r_window   <= '0;
      r_fill_cnt <= '0;
      r_primed   <= 1'b0;
      r_win_idx  <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_index  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_window <= {io_sched.s_data, r_window[WIN_LEN-1:1]};
      if (w_fill_done) begin
        r_fill_cnt <= '0;
        r_primed   <= 1'b1;
      end else if (w_accept) begin
        r_fill_cnt <= w_fill_inc;
      end
      if (r_state == S_CLEAR) r_win_idx <= r_win_idx + 16'd1;
      // r_win_idx was already bumped at launch, so the producing window is one behind it.
      if ((r_state == S_RUN) && io_sched.net_done) begin
        r_m_valid <= 1'b1;
        r_m_data  <= io_sched.net_result;
        r_m_index <= r_win_idx - 16'd1;
      end else if ((r_state == S_OUT) && io_sched.m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign io_sched.s_ready    = w_s_ready;
  assign io_sched.net_rst    = w_net_rst;
  assign io_sched.net_start  = w_net_start;
  assign io_sched.net_window = r_window;
  assign io_sched.m_valid    = r_m_valid;
  assign io_sched.m_data     = r_m_data;
  assign io_sched.m_index    = r_m_index;

endmodule

`default_nettype wire

// File: tb/tb_ppg_infer_sched.sv
// tb_ppg_infer_sched -- scoreboard bench for ppg_infer_sched with a behavioural network model. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ppg_infer_sched;
  localparam int WIN_LEN     = 24;
  localparam int HOP         = 8;
  localparam int DW          = 16;
  localparam int TIMEOUT_CYC = 1024;
  localparam int WW          = WIN_LEN * DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ppg_infer_sched_if #(.WIN_LEN(WIN_LEN), .DW(DW)) bus ();

  ppg_infer_sched #(
    .WIN_LEN(WIN_LEN), .HOP(HOP), .DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_sched(bus.master)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [15:0]   idx;
  } res_t;

  res_t          resq[$];
  logic [WW-1:0] winq[$];
  res_t          e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Network model: mode 0 = done after net_lat cycles, 1 = never done, 2 = done held high.
  int            net_mode = 0;
  int            net_lat  = 40;
  logic [DW-1:0] net_res  = '0;
  int            net_cnt  = 0;
  bit            net_busy = 1'b0;

  always @(negedge clk) begin
    bus.net_result <= net_res;
    if (reset || bus.net_rst) begin
      net_busy     <= 1'b0;
      bus.net_done <= (net_mode == 2);
    end else if (bus.net_start) begin
      net_busy     <= 1'b1;
      net_cnt      <= 0;
      bus.net_done <= (net_mode == 2);
    end else if (net_busy && net_mode == 0) begin
      net_cnt <= net_cnt + 1;
      if (net_cnt + 1 == net_lat) bus.net_done <= 1'b1;
    end else if (net_mode == 2) begin
      bus.net_done <= 1'b1;
    end
  end

  bit            prev_rst = 1'b0;
  bit            prev_hs  = 1'b0;
  bit            prev_mv  = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [15:0]   prev_idx  = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.net_start) begin
        start_cyc <= cyc;
        chk("net_rst_before_start", {{(WW-1){1'b0}}, prev_rst}, 1);
        if (winq.size() == 0) fail("unexpected_start", "net_start with no launch expected");
        else                  chk("net_window", bus.net_window, winq.pop_front());
      end
      if (prev_hs) chk("s_ready_after_hs", bus.s_ready, 1);
      if (bus.m_valid) begin
        chk("s_ready_low_in_out", bus.s_ready, 0);
        if (prev_mv && !prev_hs) begin
          chk("m_data_stable", bus.m_data, prev_data);
          chk("m_index_stable", bus.m_index, prev_idx);
        end
        if (bus.m_ready) begin
          if (resq.size() == 0) begin
            fail("unexpected_result", "m_valid handshake with no result expected");
          end else begin
            e = resq.pop_front();
            chk("m_data", bus.m_data, e.data);
            chk("m_index", bus.m_index, e.idx);
          end
        end
      end
    end
    prev_rst  <= bus.net_rst;
    prev_hs   <= bus.m_valid && bus.m_ready && !reset;
    prev_mv   <= bus.m_valid;
    prev_data <= bus.m_data;
    prev_idx  <= bus.m_index;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int t = 0;
    while (!bus.s_ready && t < 200) begin
      cycles(1);
      t++;
    end
    if (!bus.s_ready) fail("s_ready_wait", "s_ready never returned");
    bus.s_valid = 1'b1;
    bus.s_data  = DW'(v);
    cycles(1);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_range(input int a, input int b);
    for (int v = a; v <= b; v++) send(v);
  endtask

  function automatic logic [WW-1:0] win_of(input int first);
    logic [WW-1:0] w;
    for (int i = 0; i < WIN_LEN; i++) w[i*DW +: DW] = DW'(first + i);
    return w;
  endfunction

  task automatic expect_launch(input int first, input logic [DW-1:0] d, input logic [15:0] i);
    res_t r;
    r = '{d, i};
    winq.push_back(win_of(first));
    resq.push_back(r);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((winq.size() != 0 || resq.size() != 0) && t < 500) begin
      cycles(1);
      t++;
    end
    if (winq.size() != 0 || resq.size() != 0) fail("drain_timeout", "expected launch/result did not occur");
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_net_rst", bus.net_rst, 0);
    chk("rst_net_start", bus.net_start, 0);
    chk("rst_net_window", bus.net_window, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_index", bus.m_index, 0);
    chk("rst_err", bus.err, 0);
    cycles(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    cycles(3);
    reset = 1'b0;
    check_reset_vals();

    // Prime with a full window, then one hop.
    net_res = 16'h1234;
    expect_launch(1, 16'h1234, 16'd0);
    send_range(1, 24);
    wait_idle();
    net_res = 16'h0BCD;
    expect_launch(9, 16'h0BCD, 16'd1);
    send_range(25, 32);
    wait_idle();

    // Back-pressure with a sample offered while the launch is in flight.
    bus.m_ready = 1'b0;
    net_res = 16'h8001;
    expect_launch(17, 16'h8001, 16'd2);
    send_range(33, 40);
    t = 0;
    while (!bus.m_valid && t < 200) begin
      cycles(1);
      t++;
    end
    if (!bus.m_valid) fail("m_valid_wait", "m_valid never asserted");
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hDEAD;
    cycles(10);
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
    wait_idle();

    // Network holds done high across launches.
    net_mode = 2;
    net_res = 16'h0777;
    expect_launch(25, 16'h0777, 16'd3);
    send_range(41, 48);
    wait_idle();
    net_res = 16'h0778;
    expect_launch(33, 16'h0778, 16'd4);
    send_range(49, 56);
    wait_idle();
    cycles(5);
    net_mode = 0;

    // Reset while RUN is waiting on the network.
    net_res = 16'h1111;
    winq.push_back(win_of(41));
    send_range(57, 64);
    cycles(10);
    chk("start_before_reset", winq.size(), 0);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check_reset_vals();
    net_res = 16'h0ABC;
    expect_launch(101, 16'h0ABC, 16'd0);
    send_range(101, 124);
    wait_idle();

`ifdef PPG_SCHED_TIMEOUT_EN
    net_mode = 1;
    winq.push_back(win_of(109));
    send_range(125, 132);
    chk("err_before_timeout", bus.err, 0);
    t = 0;
    while (!bus.s_ready && t < 1200) begin
      cycles(1);
      t++;
    end
    chk("timeout_s_ready", bus.s_ready, 1);
    chk("timeout_len", cyc - start_cyc, TIMEOUT_CYC + 1);
    chk("timeout_err", bus.err, 1);
    net_mode = 0;
    net_res = 16'h2222;
    expect_launch(117, 16'h2222, 16'd2);
    send_range(133, 140);
    wait_idle();
    chk("err_sticky", bus.err, 1);
`else
    chk("err_tied_low", bus.err, 0);
`endif

    cycles(5);
    chk("queues_empty", winq.size() + resq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
